clock_domain_sequencer: RTL and testbench
=========================================

# clock_domain_sequencer

Parametrised power/clock sequencer for the MAKu dual-core MCU. It runs in the GP-core 100 MHz domain and drives N clock domains. Each domain gets an ordered power-up with a held reset, and power-down goes through a quiesce request/acknowledge handshake with a timeout. It also keeps a saturating per-domain active-cycle counter. Outputs feed the BUFGCE enables and the per-domain reset synchronisers.

## Interface
- NUM_DOMAINS, 4, number of sequenced domains (index 0 = highest priority); legal range 1-8
- RST_HOLD_CYCLES, 16, cycles of reset held with the clock enabled during wake; minimum 2
- ACK_TIMEOUT, 255, QUIESCE cycles before a forced gate
- CNT_W, 32, active-counter width
- clk_gp_100mhz  in  1  clock
- reset_counter_done  in  1  reset: asynchronous, active-low
- pd_req  in  NUM_DOMAINS  level power-down request per domain
- quiesce_ack  in  NUM_DOMAINS  domain-side ack; asynchronous, 2-flop synchronised internally
- cnt_clr  in  NUM_DOMAINS  synchronous clear of active_cnt[i]
- err_clr  in  1  clears all timeout_err bits
- quiesce_req  out  NUM_DOMAINS  request domain to idle
- clk_en  out  NUM_DOMAINS  clock enable to BUFGCE
- dom_rst_n  out  NUM_DOMAINS  domain reset request (active-low)
- dom_state  out  3*NUM_DOMAINS  state of domain i at [3i+2:3i]
- active_cnt  out  CNT_W*NUM_DOMAINS  domain i at [CNT_W*i +: CNT_W]
- timeout_err  out  NUM_DOMAINS  sticky forced-gate flag
- busy  out  1  any domain in WAKE, QUIESCE or GATE
- all_running  out  1  every domain in RUN

## Operation
- Per-domain FSM, encoding: OFF=0, WAKE=1, RUN=2, QUIESCE=3, GATE=4.
- Outputs are Moore-decoded from the state register. There is no combinational path from any input to any output.
  - OFF: clk_en=0, dom_rst_n=0, quiesce_req=0.
  - WAKE: clk_en=1, dom_rst_n=0.
  - RUN: clk_en=1, dom_rst_n=1.
  - QUIESCE: clk_en=1, dom_rst_n=1, quiesce_req=1.
  - GATE: clk_en=0, dom_rst_n=1.
- Single-token arbiter: at most one domain is in WAKE, QUIESCE or GATE at any time.
  - A grant is issued only in a cycle with busy=0.
  - The grant goes to the lowest-index eligible domain.
  - Eligible means OFF with pd_req=0 (grant moves it to WAKE), or RUN with pd_req=1 (grant moves it to QUIESCE).
- WAKE: a down-counter is loaded with RST_HOLD_CYCLES. The domain leaves to RUN after exactly RST_HOLD_CYCLES cycles in WAKE. pd_req is ignored during WAKE.
- QUIESCE: a timeout counter starts at 0. Transitions:
  - Synchronised ack=1 → GATE.
  - Timeout counter reaches ACK_TIMEOUT → GATE, and timeout_err[i] is set.
  - pd_req[i]=0 before either → abort to RUN; no gate, no error.
  - Ack and timeout in the same cycle: ack wins, no error.
- GATE lasts exactly 1 cycle and then goes to OFF. This guarantees the clock stops before reset asserts.
- active_cnt[i] increments in every cycle with state RUN or QUIESCE. It saturates at 2^CNT_W-1 with no wrap. cnt_clr[i] wins over increment.
- timeout_err: a set in the same cycle as err_clr wins.

## Timing
- Reset (reset_counter_done=0), all outputs:
  - All domains OFF, so clk_en=0, dom_rst_n=0, quiesce_req=0, dom_state=0.
  - active_cnt=0, timeout_err=0, busy=0, all_running=0.
  - Ack synchronisers and internal counters are cleared.
- Reset asserted mid-operation: every domain returns to OFF immediately (asynchronously). Counters and error flags clear.
- Power-up with all pd_req=0, edges numbered from the first edge after reset release:
  - Domain i enters WAKE at edge 1+(RST_HOLD_CYCLES+1)·i.
  - Domain i enters RUN RST_HOLD_CYCLES edges later.
  - One idle grant cycle separates consecutive domains.
- Quiesce with ack already high, grant at edge g:
  - Edge g: QUIESCE.
  - Edges g+1, g+2: ack passes through the synchroniser.
  - Edge g+3: GATE.
  - Edge g+4: OFF.
- Forced gate: GATE at edge g+ACK_TIMEOUT; timeout_err rises on the same edge.
- pd_req toggles are acted on at the next grant opportunity. Requests are not queued beyond the level.

## Test plan
- Power-up sequence; NUM_DOMAINS=4, RST_HOLD_CYCLES=16, pd_req=0 → domain WAKE entries at edges 1, 18, 35, 52; all_running=1 from edge 68; dom_rst_n[i] stays low for exactly 16 clk_en-high cycles.
- Domain 2 power-down, quiesce_ack[2] tied high, pd_req[2] raised while all are running → QUIESCE, then GATE 3 edges after grant, then OFF; clk_en[2] falls one cycle before dom_rst_n[2]; timeout_err=0.
- Domain 1 power-down, quiesce_ack[1] held low, ACK_TIMEOUT=255 → GATE 255 edges after grant, timeout_err[1]=1; err_clr pulse → 0; err_clr in the same cycle as a new timeout → stays 1.
- Arbitration: pd_req[3] and pd_req[0] raised simultaneously → domain 0 completes QUIESCE/GATE first; domain 3 is granted only after busy=0; busy is never set by two domains at once.
- Abort: pd_req[1] dropped 1 cycle after QUIESCE entry with ack low → back to RUN; clk_en[1] never falls; active_cnt[1] continues incrementing.
- Counters: CNT_W=4 with a domain held in RUN for 20 cycles → active_cnt saturates at 15; cnt_clr together with increment → 0; mid-run reset assertion → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/clock_domain_sequencer_if.sv
// Bundle of the sequencer's request/status signals.
//   master : drives pd_req, quiesce_ack, cnt_clr, err_clr; observes all status
//   slave  : the sequencer itself
// Per-domain vectors are indexed by domain number (0 = highest priority);
// dom_state packs 3 bits per domain, active_cnt packs CNT_W bits per domain.
interface clock_domain_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned CNT_W       = 32
);
  logic [NUM_DOMAINS-1:0]       pd_req;
  logic [NUM_DOMAINS-1:0]       quiesce_ack;
  logic [NUM_DOMAINS-1:0]       cnt_clr;
  logic                         err_clr;
  logic [NUM_DOMAINS-1:0]       quiesce_req;
  logic [NUM_DOMAINS-1:0]       clk_en;
  logic [NUM_DOMAINS-1:0]       dom_rst_n;
  logic [3*NUM_DOMAINS-1:0]     dom_state;
  logic [CNT_W*NUM_DOMAINS-1:0] active_cnt;
  logic [NUM_DOMAINS-1:0]       timeout_err;
  logic                         busy;
  logic                         all_running;

  modport master (
    output pd_req, quiesce_ack, cnt_clr, err_clr,
    input  quiesce_req, clk_en, dom_rst_n, dom_state, active_cnt,
           timeout_err, busy, all_running
  );

  modport slave (
    input  pd_req, quiesce_ack, cnt_clr, err_clr,
    output quiesce_req, clk_en, dom_rst_n, dom_state, active_cnt,
           timeout_err, busy, all_running
  );
endinterface

// File: rtl/clock_domain_sequencer.sv
// Power/clock sequencer for N clock domains in the GP-core 100 MHz domain.
// Each domain: OFF -> WAKE (clock on, reset held) -> RUN -> QUIESCE (idle
// handshake with timeout) -> GATE (clock off, one cycle) -> OFF.
// A single token means at most one domain is ever in WAKE/QUIESCE/GATE.
// Ports:
//   clk_gp_100mhz      : clock
//   reset_counter_done : asynchronous active-low reset
//   seq_if             : request inputs and Moore-decoded status outputs
module clock_domain_sequencer #(
  parameter int unsigned NUM_DOMAINS     = 4,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT     = 255,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                    clk_gp_100mhz,
  input  logic                    reset_counter_done,
  clock_domain_sequencer_if.slave seq_if
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAKE    = 3'd1,
    ST_RUN     = 3'd2,
    ST_QUIESCE = 3'd3,
    ST_GATE    = 3'd4
  } dom_state_e;

  localparam int unsigned TMR_MAX = (RST_HOLD_CYCLES > ACK_TIMEOUT) ? RST_HOLD_CYCLES : ACK_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  dom_state_e                        state_q [NUM_DOMAINS];
  dom_state_e                        state_d [NUM_DOMAINS];
  // Only the token holder uses the timer, so one is shared by all domains.
  logic [TMR_W-1:0]                  tmr_q, tmr_d;
  logic [NUM_DOMAINS-1:0]            ack_s1_q, ack_s1_d;
  logic [NUM_DOMAINS-1:0]            ack_s2_q, ack_s2_d;
  logic [NUM_DOMAINS-1:0]            err_q, err_d;
  logic [NUM_DOMAINS-1:0]            err_set;
  logic [NUM_DOMAINS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                              busy_w;
  logic                              all_run_w;
  logic                              granted;

  always_ff @(posedge clk_gp_100mhz or negedge reset_counter_done) begin
    if (!reset_counter_done) begin
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) state_q[i] <= ST_OFF;
      tmr_q    <= '0;
      ack_s1_q <= '0;
      ack_s2_q <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) state_q[i] <= state_d[i];
      tmr_q    <= tmr_d;
      ack_s1_q <= ack_s1_d;
      ack_s2_q <= ack_s2_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    busy_w    = 1'b0;
    all_run_w = 1'b1;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      if (state_q[i] inside {ST_WAKE, ST_QUIESCE, ST_GATE}) busy_w = 1'b1;
      if (state_q[i] != ST_RUN) all_run_w = 1'b0;
    end
  end

  // Grants are only considered while the token is free; otherwise only the
  // token holder advances.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) state_d[i] = state_q[i];
    tmr_d   = tmr_q;
    err_set = '0;
    granted = 1'b0;
    if (!busy_w) begin
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
        if (!granted) begin
          if (state_q[i] == ST_OFF && !seq_if.pd_req[i]) begin
            state_d[i] = ST_WAKE;
            tmr_d      = TMR_W'(RST_HOLD_CYCLES);
            granted    = 1'b1;
          end else if (state_q[i] == ST_RUN && seq_if.pd_req[i]) begin
            state_d[i] = ST_QUIESCE;
            tmr_d      = '0;
            granted    = 1'b1;
          end
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
        case (state_q[i])
          ST_WAKE: begin
            if (tmr_q == TMR_W'(1)) state_d[i] = ST_RUN;
            else                    tmr_d      = tmr_q - TMR_W'(1);
          end
          ST_QUIESCE: begin
            // Ack beats timeout, both beat an abort.
            if (ack_s2_q[i]) begin
              state_d[i] = ST_GATE;
            end else if ((tmr_q + TMR_W'(1)) == TMR_W'(ACK_TIMEOUT)) begin
              state_d[i] = ST_GATE;
              err_set[i] = 1'b1;
            end else if (!seq_if.pd_req[i]) begin
              state_d[i] = ST_RUN;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
          ST_GATE: state_d[i] = ST_OFF;
          default: ;
        endcase
      end
    end
  end

  // Synchroniser is held clear outside QUIESCE so a stale ack cannot skip
  // the two-stage latency on entry.
  always_comb begin
    ack_s1_d = '0;
    ack_s2_d = '0;
    cnt_d    = cnt_q;
    err_d    = err_set | (err_q & {NUM_DOMAINS{~seq_if.err_clr}});
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      if (state_q[i] == ST_QUIESCE) begin
        ack_s1_d[i] = seq_if.quiesce_ack[i];
        ack_s2_d[i] = ack_s1_q[i];
      end
      if (seq_if.cnt_clr[i]) begin
        cnt_d[i] = '0;
      end else if ((state_q[i] == ST_RUN || state_q[i] == ST_QUIESCE) && !(&cnt_q[i])) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    seq_if.clk_en      = '0;
    seq_if.dom_rst_n   = '0;
    seq_if.quiesce_req = '0;
    seq_if.dom_state   = '0;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      seq_if.dom_state[3*i +: 3] = state_q[i];
      case (state_q[i])
        ST_WAKE:    seq_if.clk_en[i] = 1'b1;
        ST_RUN: begin
          seq_if.clk_en[i]    = 1'b1;
          seq_if.dom_rst_n[i] = 1'b1;
        end
        ST_QUIESCE: begin
          seq_if.clk_en[i]      = 1'b1;
          seq_if.dom_rst_n[i]   = 1'b1;
          seq_if.quiesce_req[i] = 1'b1;
        end
        ST_GATE:    seq_if.dom_rst_n[i] = 1'b1;
        default: ;
      endcase
    end
  end

  assign seq_if.active_cnt  = cnt_q;
  assign seq_if.timeout_err = err_q;
  assign seq_if.busy        = busy_w;
  assign seq_if.all_running = all_run_w;

endmodule

// File: tb/tb_clock_domain_sequencer.sv
// Self-checking bench for clock_domain_sequencer: directed scenarios plus a
// randomized soak, compared every cycle against a deadline-based model.
module tb_clock_domain_sequencer;
  localparam int unsigned N  = 4;
  localparam int unsigned H  = 16;
  localparam int unsigned T  = 255;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_domain_sequencer_if #(.NUM_DOMAINS(N), .CNT_W(CW)) bus ();

  clock_domain_sequencer #(
    .NUM_DOMAINS(N), .RST_HOLD_CYCLES(H), .ACK_TIMEOUT(T), .CNT_W(CW)
  ) dut (
    .clk_gp_100mhz(clk),
    .reset_counter_done(rst_n),
    .seq_if(bus)
  );

  // Model: state codes 0..4, with transition deadlines per domain.
  int     ms [N];
  int     wake_end [N];
  int     q_grant [N];
  int     mcnt [N];
  bit     merr [N];
  bit [N-1:0] ack_p1, ack_p2;
  int     edge_n;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ms[i] = 0; wake_end[i] = 0; q_grant[i] = 0; mcnt[i] = 0; merr[i] = 0;
    end
    ack_p1 = '0; ack_p2 = '0; edge_n = 0;
  endtask

  task automatic model_step();
    int  nx [N];
    bit  holder, given;
    edge_n++;
    nx = ms;
    holder = 0;
    given  = 0;
    for (int i = 0; i < N; i++) if (ms[i] == 1 || ms[i] == 3 || ms[i] == 4) holder = 1;
    if (!holder) begin
      for (int i = 0; i < N; i++) begin
        if (!given && ms[i] == 0 && !bus.pd_req[i]) begin
          nx[i] = 1; wake_end[i] = edge_n + H; given = 1;
        end else if (!given && ms[i] == 2 && bus.pd_req[i]) begin
          nx[i] = 3; q_grant[i] = edge_n; given = 1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ms[i] == 1 && edge_n == wake_end[i]) nx[i] = 2;
        else if (ms[i] == 3) begin
          if (edge_n >= q_grant[i] + 3 && ack_p2[i]) nx[i] = 4;
          else if (edge_n == q_grant[i] + T) begin nx[i] = 4; merr[i] = 1; end
          else if (!bus.pd_req[i]) nx[i] = 2;
        end
        else if (ms[i] == 4) nx[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.cnt_clr[i]) mcnt[i] = 0;
      else if ((ms[i] == 2 || ms[i] == 3) && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
      // err_clr only clears flags that were not set on this edge
      if (bus.err_clr && !(nx[i] == 4 && ms[i] == 3 && !(edge_n >= q_grant[i] + 3 && ack_p2[i])))
        merr[i] = 0;
    end
    ack_p2 = ack_p1;
    ack_p1 = bus.quiesce_ack;
    ms = nx;
  endtask

  task automatic compare_all();
    logic [N-1:0]    e_ce, e_rn, e_qr, e_err;
    logic [3*N-1:0]  e_st;
    logic [CW*N-1:0] e_cnt;
    logic            e_busy, e_all;
    int              nb;
    e_busy = 0; e_all = 1; nb = 0;
    for (int i = 0; i < N; i++) begin
      e_st[3*i +: 3]   = 3'(ms[i]);
      e_ce[i]          = (ms[i] >= 1 && ms[i] <= 3);
      e_rn[i]          = (ms[i] >= 2);
      e_qr[i]          = (ms[i] == 3);
      e_cnt[CW*i +: CW] = CW'(mcnt[i]);
      e_err[i]         = merr[i];
      if (ms[i] == 1 || ms[i] == 3 || ms[i] == 4) e_busy = 1;
      if (ms[i] != 2) e_all = 0;
      if (bus.dom_state[3*i +: 3] inside {3'd1, 3'd3, 3'd4}) nb++;
    end
    check_eq("dom_state",   bus.dom_state,   e_st);
    check_eq("clk_en",      bus.clk_en,      e_ce);
    check_eq("dom_rst_n",   bus.dom_rst_n,   e_rn);
    check_eq("quiesce_req", bus.quiesce_req, e_qr);
    check_eq("active_cnt",  bus.active_cnt,  e_cnt);
    check_eq("timeout_err", bus.timeout_err, e_err);
    check_eq("busy",        bus.busy,        e_busy);
    check_eq("all_running", bus.all_running, e_all);
    check_eq("one_token",   (nb > 1),        1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_all_run(input int limit);
    int k;
    k = 0;
    while (!bus.all_running && k < limit) begin cycle(); k++; end
    check_eq("all_run_reached", bus.all_running, 1'b1);
  endtask

  initial begin
    int hold_cnt [N];
    int qe, ge, cf, rf, q0, q3, b;
    bit ce_fell;

    bus.pd_req = '0; bus.quiesce_ack = '0; bus.cnt_clr = '0; bus.err_clr = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) hold_cnt[i] = 0;
    #23;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up ordering
    for (int e = 1; e <= 70; e++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (bus.clk_en[i] && !bus.dom_rst_n[i]) hold_cnt[i]++;
        if (e == 1 + 17 * i) check_eq("wake_entry", bus.dom_state[3*i +: 3], 3'd1);
      end
      if (e == 67) check_eq("all_run_e67", bus.all_running, 1'b0);
      if (e == 68) check_eq("all_run_e68", bus.all_running, 1'b1);
    end
    for (int i = 0; i < N; i++) check_eq("rst_hold_len", 32'(hold_cnt[i]), 32'(H));
    check_eq("cnt0_saturated", bus.active_cnt[CW-1:0], 4'd15);

    // Domain 2 power-down with ack already high
    bus.quiesce_ack = 4'b0100;
    bus.pd_req      = 4'b0100;
    qe = -1; ge = -1; cf = -1; rf = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (qe < 0 && bus.dom_state[8:6] == 3'd3) qe = edge_n;
      if (ge < 0 && bus.dom_state[8:6] == 3'd4) ge = edge_n;
      if (cf < 0 && !bus.clk_en[2]) cf = edge_n;
      if (rf < 0 && !bus.dom_rst_n[2]) rf = edge_n;
    end
    check_eq("d2_grant_to_gate", 32'(ge - qe), 32'd3);
    check_eq("d2_clk_before_rst", 32'(rf - cf), 32'd1);
    check_eq("d2_no_err", bus.timeout_err, 4'd0);
    bus.pd_req = '0;
    wait_all_run(100);

    // Domain 1 forced gate
    bus.quiesce_ack = 4'b0100;
    bus.pd_req      = 4'b0010;
    qe = -1; ge = -1;
    for (int k = 0; k < 300 && ge < 0; k++) begin
      cycle();
      if (qe < 0 && bus.dom_state[5:3] == 3'd3) qe = edge_n;
      if (ge < 0 && bus.dom_state[5:3] == 3'd4) begin
        ge = edge_n;
        check_eq("d1_err_at_gate", bus.timeout_err[1], 1'b1);
      end
    end
    check_eq("d1_timeout_len", 32'(ge - qe), 32'(T));
    cycle();
    bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0;
    check_eq("d1_err_cleared", bus.timeout_err[1], 1'b0);
    bus.pd_req = '0;
    wait_all_run(100);

    // New timeout coinciding with err_clr
    bus.pd_req = 4'b0010;
    ge = -1;
    for (int k = 0; k < 300 && ge < 0; k++) begin
      cycle();
      bus.err_clr = (ms[1] == 3 && edge_n + 1 == q_grant[1] + int'(T));
      if (bus.dom_state[5:3] == 3'd4) begin
        ge = edge_n;
        check_eq("err_set_beats_clr", bus.timeout_err[1], 1'b1);
      end
    end
    check_eq("d1_second_gate_seen", (ge >= 0), 1'b1);
    bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0;
    bus.pd_req  = '0;
    wait_all_run(100);

    // Arbitration: domains 0 and 3 together
    bus.quiesce_ack = 4'b1001;
    bus.pd_req      = 4'b1001;
    q0 = -1; q3 = -1;
    for (int k = 0; k < 60 && q3 < 0; k++) begin
      cycle();
      if (q0 < 0 && bus.dom_state[2:0] == 3'd3) q0 = edge_n;
      if (q3 < 0 && bus.dom_state[11:9] == 3'd3) q3 = edge_n;
    end
    check_eq("arb_d0_first", (q0 >= 0 && q3 > q0), 1'b1);
    check_eq("arb_d3_after_free", 32'(q3 - q0), 32'd5);
    bus.pd_req = '0;
    wait_all_run(200);

    // Abort: pd_req[1] dropped one cycle after QUIESCE entry
    bus.quiesce_ack = '0;
    bus.pd_req      = 4'b0010;
    qe = -1;
    for (int k = 0; k < 20 && qe < 0; k++) begin
      cycle();
      if (bus.dom_state[5:3] == 3'd3) qe = edge_n;
    end
    check_eq("abort_quiesce_seen", (qe >= 0), 1'b1);
    ce_fell = !bus.clk_en[1];
    cycle();
    ce_fell |= !bus.clk_en[1];
    bus.pd_req  = '0;
    bus.cnt_clr = 4'b0010;
    cycle();
    bus.cnt_clr = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      ce_fell |= !bus.clk_en[1];
    end
    check_eq("abort_clk_kept", ce_fell, 1'b0);
    check_eq("abort_back_run", bus.dom_state[5:3], 3'd2);
    check_eq("abort_cnt_runs", bus.active_cnt[2*CW-1:CW], 4'd8);

    // Randomized soak with a mid-run asynchronous reset
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(39) == 0) begin
        b = $urandom_range(N - 1);
        bus.pd_req[b] = ~bus.pd_req[b];
      end
      if ($urandom_range(63) == 0) begin
        b = $urandom_range(N - 1);
        bus.quiesce_ack[b] = ~bus.quiesce_ack[b];
      end
      bus.cnt_clr = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) bus.cnt_clr[i] = 1'b1;
      bus.err_clr = ($urandom_range(31) == 0);
      cycle();
      if (k == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle();
        cycle();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
